// File: rtl/data_mem_responder.sv
// Slow data-memory responder: accepts one word access per request, answers after WAIT_STATES idle cycles.
// Optional per-byte write enables when DATA_MEM_BYTE_LANE_EN is defined (adds the ByteEn port).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
`ifdef DATA_MEM_BYTE_LANE_EN
  input  logic [3:0]  ByteEn,
`endif
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, enter_resp;

  logic        cap_we;
  logic [31:0] cap_adr, cap_wdata;
  logic [3:0]  cap_be;

  logic        acc_we, acc_bad;
  logic [31:0] acc_adr, acc_wdata;
  logic [3:0]  acc_be, be_in;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

`ifdef DATA_MEM_BYTE_LANE_EN
  assign be_in = ByteEn;
`else
  assign be_in = 4'hF;
`endif

  // Handshake: req is held by the requester until it samples ready=1; a request is
  // accepted only in IDLE, and ready is a one-cycle strobe in RESP with err/ReadData valid.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_nx = WS;
          if (WS == 4'd0) begin
            state_nx   = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx   = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_adr   <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
    end else if (accept) begin
      cap_we    <= MemWrite;
      cap_adr   <= DataAdr;
      cap_wdata <= WriteData;
      cap_be    <= be_in;
    end
  end

  // With zero wait states the access completes on the accepting edge, so use the live inputs.
  always_comb begin
    if (state == S_IDLE) begin
      acc_we    = MemWrite;
      acc_adr   = DataAdr;
      acc_wdata = WriteData;
      acc_be    = be_in;
    end else begin
      acc_we    = cap_we;
      acc_adr   = cap_adr;
      acc_wdata = cap_wdata;
      acc_be    = cap_be;
    end
    acc_bad = (acc_adr[1:0] != 2'b00) || (acc_adr[31:2] >= DEPTH_LIM);
    acc_idx = acc_adr[AW+1:2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      if (enter_resp) begin
        err_q <= acc_bad;
        if (!acc_bad && !acc_we) rdata_q <= mem[acc_idx];
      end
    end
  end

  // Storage is not reset; the reset qualifier keeps an access aborted by reset from committing.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign ready     = (state == S_RESP);
  assign err       = err_q;
  assign ReadData  = rdata_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, hand-written reset/latency sequences,
// and random accesses checked against a word-array model of the memory.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;
`ifdef DATA_MEM_BYTE_LANE_EN
  localparam logic BE_EN = 1'b1;
`else
  localparam logic BE_EN = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req, mem_write;
  logic [31:0] data_adr, write_data, read_data;
  logic [3:0]  byte_en;
  logic        ready, err_o;
  logic [1:0]  fsm_state;

  logic        req0, mem_write0;
  logic [31:0] data_adr0, write_data0, read_data0;
  logic        ready0, err0;
  logic [1:0]  fsm_state0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .MemWrite(mem_write),
    .DataAdr(data_adr), .WriteData(write_data),
`ifdef DATA_MEM_BYTE_LANE_EN
    .ByteEn(byte_en),
`endif
    .ReadData(read_data), .ready(ready), .err(err_o), .fsm_state(fsm_state)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .MemWrite(mem_write0),
    .DataAdr(data_adr0), .WriteData(write_data0),
`ifdef DATA_MEM_BYTE_LANE_EN
    .ByteEn(4'hF),
`endif
    .ReadData(read_data0), .ready(ready0), .err(err0), .fsm_state(fsm_state0)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_mem[DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(input logic [31:0] adr);
    return ((adr % 32'd4) != 32'd0) || ((adr / 32'd4) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    return model_err(adr) ? 32'd0 : model_mem[int'(adr / 32'd4)];
  endfunction

  task automatic model_apply(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                             input logic [3:0] be);
    logic [31:0] w;
    if (we && !model_err(adr)) begin
      w = model_mem[int'(adr / 32'd4)];
      for (int i = 0; i < 4; i++)
        if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model_mem[int'(adr / 32'd4)] = w;
    end
  endtask

  // driver: starts at a negedge with the DUT idle, ends at the negedge after the response
  task automatic run_access(input string tag, input logic we, input logic [31:0] adr,
                            input logic [31:0] wdata, input logic [3:0] be, input logic hold,
                            input logic exp_err, input logic [31:0] exp_rdata);
    logic [32:0] e;
    req = 1'b1; mem_write = we; data_adr = adr; write_data = wdata; byte_en = be;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    if (!hold) begin
      req        = 1'b0;
      mem_write  = 1'($urandom_range(0, 1));
      data_adr   = $urandom;
      write_data = $urandom;
      byte_en    = 4'($urandom_range(0, 15));
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check({tag, " ready_early"}, 64'(ready), 64'd0);
    end
    @(negedge clk);
    check({tag, " ready"}, 64'(ready), 64'd1);
    e = exp_q.pop_front();
    check({tag, " err_rdata"}, 64'({err_o, read_data}), 64'(e));
    req = 1'b0;
    @(negedge clk);
    check({tag, " after_resp"}, 64'({fsm_state, ready, err_o, read_data}), 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [31:0] adr, wd;
    logic        we;
    logic [3:0]  be;
    int          r;

    tbl[0]  = '{1'b1, 32'd100,        32'd7,         4'hF, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 32'd100,        32'd0,         4'hF, 1'b0, 32'd7};
    tbl[2]  = '{1'b1, 32'd96,         32'hDEADBEEF,  4'hF, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 32'd96,         32'd0,         4'hF, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 32'd252,        32'h0BADF00D,  4'hF, 1'b0, 32'd0};
    tbl[5]  = '{1'b1, 32'd102,        32'h11111111,  4'hF, 1'b1, 32'd0};
    tbl[6]  = '{1'b1, 32'd256,        32'h22222222,  4'hF, 1'b1, 32'd0};
    tbl[7]  = '{1'b0, 32'd100,        32'd0,         4'hF, 1'b0, 32'd7};
    tbl[8]  = '{1'b0, 32'd252,        32'd0,         4'hF, 1'b0, 32'h0BADF00D};
    tbl[9]  = '{1'b0, 32'd256,        32'd0,         4'hF, 1'b1, 32'd0};
    tbl[10] = '{1'b0, 32'd98,         32'd0,         4'hF, 1'b1, 32'd0};
    tbl[11] = '{1'b0, 32'd101,        32'd0,         4'hF, 1'b1, 32'd0};
    tbl[12] = '{1'b0, 32'hFFFFFFFC,   32'd0,         4'hF, 1'b1, 32'd0};
    tbl[13] = '{1'b1, 32'd0,          32'hCAFEF00D,  4'hF, 1'b0, 32'd0};
    tbl[14] = '{1'b0, 32'd0,          32'd0,         4'hF, 1'b0, 32'hCAFEF00D};
    tbl[15] = '{1'b1, 32'd8,          32'd0,         4'hF, 1'b0, 32'd0};
    tbl[16] = '{1'b0, 32'd8,          32'd0,         4'hF, 1'b0, 32'd0};

    req = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0; byte_en = 4'hF;
    req0 = 1'b0; mem_write0 = 1'b0; data_adr0 = '0; write_data0 = '0;

    #10;
    check("reset_outputs", 64'({fsm_state, ready, err_o, read_data}), 64'd0);
    #12 reset = 1'b1;
    @(negedge clk);

    // preload every word so all later reads have known contents
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      run_access("init", 1'b1, 32'(i * 4), wd, 4'hF, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
      model_apply(1'b1, 32'(i * 4), wd, 4'hF);
    end

    for (int i = 0; i < 17; i++) begin
      run_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].wdata, tbl[i].be,
                 1'(i % 2), tbl[i].exp_err, tbl[i].exp_rdata);
      model_apply(tbl[i].we, tbl[i].adr, tbl[i].wdata, tbl[i].be);
    end

    // reset in WAIT of a write: nothing committed
    req = 1'b1; mem_write = 1'b1; data_adr = 32'd8; write_data = 32'h12345678; byte_en = 4'hF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_wait_outputs", 64'({fsm_state, ready, err_o, read_data}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_access("rd_after_rst", 1'b0, 32'd8, 32'd0, 4'hF, 1'b0, 1'b0, model_read(32'd8));
    check("rst_no_commit", 64'(model_read(32'd8) == 32'h12345678), 64'd0);

    // reset while ready is high clears the strobe immediately
    req = 1'b1; mem_write = 1'b0; data_adr = 32'd96; byte_en = 4'hF;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (W + 1) @(negedge clk);
    check("rst_resp_pre", 64'({ready, read_data}), 64'({1'b1, 32'hDEADBEEF}));
    reset = 1'b0;
    #1 check("rst_resp_outputs", 64'({fsm_state, ready, err_o, read_data}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // zero-wait instance with req held high: write, then back-to-back reads every 2 cycles
    req0 = 1'b1; mem_write0 = 1'b1; data_adr0 = 32'd4; write_data0 = 32'hA5A50001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("ws0_ready_k%0d", k), 64'(ready0), 64'((k % 2) == 0));
      if (k == 0) begin
        check("ws0_write_resp", 64'({err0, read_data0}), 64'd0);
        mem_write0 = 1'b0;
      end else if ((k % 2) == 0) begin
        check($sformatf("ws0_read_k%0d", k), 64'({err0, read_data0}), 64'({1'b0, 32'hA5A50001}));
      end
    end
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ws0_idle", 64'({fsm_state0, ready0}), 64'd0);

    if (BE_EN) begin
      run_access("be_full", 1'b1, 32'd40, 32'hAABBCCDD, 4'hF, 1'b1, 1'b0, 32'd0);
      model_apply(1'b1, 32'd40, 32'hAABBCCDD, 4'hF);
      run_access("be_lane0", 1'b1, 32'd40, 32'h00000011, 4'h1, 1'b0, 1'b0, 32'd0);
      model_apply(1'b1, 32'd40, 32'h00000011, 4'h1);
      run_access("be_rd1", 1'b0, 32'd40, 32'd0, 4'h0, 1'b1, 1'b0, 32'hAABBCC11);
      run_access("be_none", 1'b1, 32'd40, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'd0);
      run_access("be_rd2", 1'b0, 32'd40, 32'd0, 4'hF, 1'b0, 1'b0, 32'hAABBCC11);
    end

    // random accesses against the model
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       adr = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) adr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else             adr = 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = BE_EN ? 4'($urandom_range(0, 15)) : 4'hF;
      run_access($sformatf("rnd%0d", n), we, adr, wd, be, 1'($urandom_range(0, 1)),
                 model_err(adr), we ? 32'd0 : model_read(adr));
      model_apply(we, adr, wd, be);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
